// File: rtl/rv_pkg.sv
// Shared types and constants for the RV front end.
// Holds the fetch FSM state encoding and the NOP used for IF/ID bubbles.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2,
        S_KILL = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry {pc, inst} holding register.
// Catches an instruction that returned while ID could not accept it.
module if_fetch_buf
    import rv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         wr_i,
    input  logic         drain_i,
    input  logic [W-1:0] wr_pc_i,
    input  logic [W-1:0] wr_inst_i,
    output logic         full_o,
    output logic [W-1:0] pc_o,
    output logic [W-1:0] inst_o
);

    logic         full_r;
    logic [W-1:0] pc_r;
    logic [W-1:0] inst_r;

    // Entry storage: clear wins over write, write wins over drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_r <= 1'b0;
            pc_r   <= '0;
            inst_r <= W'(NOP_INST);
        end else if (clr_i) begin
            full_r <= 1'b0;
        end else if (wr_i) begin
            full_r <= 1'b1;
            pc_r   <= wr_pc_i;
            inst_r <= wr_inst_i;
        end else if (drain_i) begin
            full_r <= 1'b0;
        end
    end

    assign full_o = full_r;
    assign pc_o   = pc_r;
    assign inst_o = inst_r;

endmodule

// File: rtl/if_fetch_chk.sv
// Protocol checks for the fetch stage's single-outstanding imem interface.
// Simulation-only observer; it drives nothing.
module if_fetch_chk
    import rv_pkg::*;
(
    input logic         clk_i,
    input logic         rst_i,
    input fetch_state_e state_i,
    input logic         imem_req_i,
    input logic         imem_rvalid_i
);

    // A response may only arrive while a request is outstanding.
    a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> (state_i == S_WAIT || state_i == S_KILL))
        else $error("if_fetch_chk: rvalid with no request outstanding");

    // A killed request must drain before any new request goes out.
    a_no_req_in_kill: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_req_i |-> (state_i != S_KILL))
        else $error("if_fetch_chk: request issued while draining a killed fetch");

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding imem
// protocol and feeds the IF/ID register under hazard-unit control.
module if_fetch_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_enable_i,
    input  logic            id_enable_i,
    input  logic            id_reset_ni,
    input  logic            br_sel_i,
    input  logic [XLEN-1:0] br_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_inst_o,
    output logic            id_valid_o,
    output logic            fetch_busy_o
);

    import rv_pkg::fetch_state_e;
    import rv_pkg::S_IDLE;
    import rv_pkg::S_WAIT;
    import rv_pkg::S_FULL;
    import rv_pkg::S_KILL;
    import rv_pkg::NOP_INST;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    fetch_state_e    state_r, state_nxt_s;
    logic [XLEN-1:0] pc_r, pc_nxt_s, addr_s;
    logic            req_s, advance_s, avail_s, load_s;
    logic            buf_wr_s, buf_drain_s, buf_clr_s, buf_full_s;
    logic [XLEN-1:0] buf_pc_s, buf_inst_s;
    logic [XLEN-1:0] id_pc_r, id_inst_r;
    logic            id_valid_r;

    assign advance_s = pc_enable_i & id_enable_i & id_reset_ni;
    assign avail_s   = buf_full_s | ((state_r == S_WAIT) & imem_rvalid_i);
    assign load_s    = id_enable_i & pc_enable_i & avail_s & ~br_sel_i;

    // Next-state, PC and request generation; a redirect overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        addr_s      = pc_r;
        req_s       = 1'b0;
        buf_wr_s    = 1'b0;
        buf_drain_s = 1'b0;
        buf_clr_s   = 1'b0;
        if (br_sel_i) begin
            pc_nxt_s  = br_target_i & ALIGN_MASK;
            buf_clr_s = 1'b1;
            if ((state_r == S_WAIT || state_r == S_KILL) && !imem_rvalid_i) begin
                state_nxt_s = S_KILL;
            end else begin
                state_nxt_s = S_IDLE;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (pc_enable_i) begin
                        req_s       = 1'b1;
                        state_nxt_s = S_WAIT;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i && advance_s) begin
                        // Back-to-back: the new request already targets the next word.
                        pc_nxt_s = pc_r + PC_STEP;
                        addr_s   = pc_r + PC_STEP;
                        req_s    = 1'b1;
                    end else if (imem_rvalid_i) begin
                        pc_nxt_s    = pc_r + PC_STEP;
                        buf_wr_s    = 1'b1;
                        state_nxt_s = S_FULL;
                    end else begin
                        state_nxt_s = S_WAIT;
                    end
                end
                S_FULL: begin
                    if (advance_s) begin
                        buf_drain_s = 1'b1;
                        req_s       = 1'b1;
                        state_nxt_s = S_WAIT;
                    end else begin
                        state_nxt_s = S_FULL;
                    end
                end
                S_KILL: begin
                    if (imem_rvalid_i) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_KILL;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // PC and FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    if_fetch_buf #(.W(XLEN)) u_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (buf_clr_s),
        .wr_i      (buf_wr_s),
        .drain_i   (buf_drain_s),
        .wr_pc_i   (pc_r),
        .wr_inst_i (imem_rdata_i),
        .full_o    (buf_full_s),
        .pc_o      (buf_pc_s),
        .inst_o    (buf_inst_s)
    );

    // IF/ID register: flush beats hold, hold beats load; no load means bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_pc_r    <= '0;
            id_inst_r  <= XLEN'(NOP_INST);
            id_valid_r <= 1'b0;
        end else if (!id_reset_ni) begin
            id_inst_r  <= XLEN'(NOP_INST);
            id_valid_r <= 1'b0;
        end else if (!id_enable_i) begin
            id_valid_r <= id_valid_r;
        end else if (load_s) begin
            id_pc_r    <= buf_full_s ? buf_pc_s : pc_r;
            id_inst_r  <= buf_full_s ? buf_inst_s : imem_rdata_i;
            id_valid_r <= 1'b1;
        end else begin
            id_inst_r  <= XLEN'(NOP_INST);
            id_valid_r <= 1'b0;
        end
    end

    assign imem_req_o   = req_s & ~rst_i;
    assign imem_addr_o  = rst_i ? RESET_PC : addr_s;
    assign fetch_busy_o = id_enable_i & pc_enable_i & ~avail_s & ~rst_i;
    assign id_pc_o      = id_pc_r;
    assign id_inst_o    = id_inst_r;
    assign id_valid_o   = id_valid_r;

    if_fetch_chk u_chk (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .state_i       (state_r),
        .imem_req_i    (imem_req_o),
        .imem_rvalid_i (imem_rvalid_i)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a variable-latency imem model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, pc_en, id_en, id_rn, br;
    logic [31:0] tgt;
    logic        imem_req, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] id_pc, id_inst;
    logic        id_valid, busy;

    int          total = 0;
    int          bad = 0;
    int          lat = 1;
    int          cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] maddr = 32'h0;

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_enable_i   (pc_en),
        .id_enable_i   (id_en),
        .id_reset_ni   (id_rn),
        .br_sel_i      (br),
        .br_target_i   (tgt),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .id_pc_o       (id_pc),
        .id_inst_o     (id_inst),
        .id_valid_o    (id_valid),
        .fetch_busy_o  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[23:0], 8'h6F};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: capture the request, advance the imem model after the edge.
    task automatic tick();
        logic        r_req, r_rv;
        logic [31:0] r_addr;
        #1;
        r_req  = imem_req;
        r_addr = imem_addr;
        r_rv   = imem_rvalid;
        @(posedge clk);
        #1;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (r_rv) pend = 1'b0;
            else if (pend) cnt = cnt - 1;
            if (r_req) begin
                pend  = 1'b1;
                cnt   = lat - 1;
                maddr = r_addr;
            end
        end
        imem_rvalid = pend && (cnt == 0);
        imem_rdata  = imem_rvalid ? inst_of(maddr) : 32'h0;
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_en = 1'b1; id_en = 1'b1; id_rn = 1'b1; br = 1'b0; tgt = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        tick(); tick();
        check_eq("rst_valid", {31'h0, id_valid}, 32'h0);
        check_eq("rst_inst", id_inst, NOP);
        check_eq("rst_pc", id_pc, 32'h0);
        check_eq("rst_req", {31'h0, imem_req}, 32'h0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);

        // 1: streaming with latency-1 memory
        rst = 1'b0; #1;
        check_eq("t1_req0", {31'h0, imem_req}, 32'h1);
        check_eq("t1_addr0", imem_addr, 32'h0);
        check_eq("t1_busy0", {31'h0, busy}, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq("t1_req", {31'h0, imem_req}, 32'h1);
            check_eq("t1_addr", imem_addr, 32'(4 * i));
            if (i >= 2) begin
                check_eq("t1_id_pc", id_pc, 32'(4 * (i - 2)));
                check_eq("t1_id_valid", {31'h0, id_valid}, 32'h1);
                check_eq("t1_id_inst", id_inst, inst_of(32'(4 * (i - 2))));
            end
        end

        // 2: freeze while the response for 0x8 lands in the buffer
        pc_en = 1'b0; id_en = 1'b0; #1;
        check_eq("t2_noreq0", {31'h0, imem_req}, 32'h0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check_eq("t2_noreq", {31'h0, imem_req}, 32'h0);
            check_eq("t2_hold_pc", id_pc, 32'h4);
            check_eq("t2_addr", imem_addr, 32'hC);
        end
        pc_en = 1'b1; id_en = 1'b1; #1;
        check_eq("t2_req_c", {31'h0, imem_req}, 32'h1);
        check_eq("t2_addr_c", imem_addr, 32'hC);
        check_eq("t2_busy", {31'h0, busy}, 32'h0);
        tick();
        check_eq("t2_id_pc8", id_pc, 32'h8);
        check_eq("t2_id_inst8", id_inst, inst_of(32'h8));
        check_eq("t2_addr10", imem_addr, 32'h10);

        // 3: latency-3 memory, redirect while 0x10 is in flight
        lat = 3;
        tick();
        check_eq("t3_id_pcc", id_pc, 32'hC);
        br = 1'b1; tgt = 32'h0000_0103; #1;
        check_eq("t3_busy", {31'h0, busy}, 32'h1);
        check_eq("t3_noreq", {31'h0, imem_req}, 32'h0);
        tick();
        br = 1'b0; #1;
        check_eq("t3_addr100", imem_addr, 32'h100);
        check_eq("t3_kill_noreq", {31'h0, imem_req}, 32'h0);
        for (int n = 0; n < 10 && !imem_req; n++) tick();
        check_eq("t3_req_wait", {31'h0, imem_req}, 32'h1);
        check_eq("t3_req_addr", imem_addr, 32'h100);
        check_eq("t3_dropped", {31'h0, id_valid}, 32'h0);
        for (int n = 0; n < 10 && !id_valid; n++) tick();
        check_eq("t3_valid_wait", {31'h0, id_valid}, 32'h1);
        check_eq("t3_id_pc100", id_pc, 32'h100);
        check_eq("t3_id_inst100", id_inst, inst_of(32'h100));

        // 4: flush IF/ID while an instruction sits in the buffer
        pc_en = 1'b0;
        tick(); tick(); tick();
        check_eq("t4_full_noreq", {31'h0, imem_req}, 32'h0);
        check_eq("t4_full_addr", imem_addr, 32'h108);
        id_rn = 1'b0; pc_en = 1'b1; #1;
        check_eq("t4_flush_noreq", {31'h0, imem_req}, 32'h0);
        tick();
        check_eq("t4_flush_valid", {31'h0, id_valid}, 32'h0);
        check_eq("t4_flush_inst", id_inst, NOP);
        id_rn = 1'b1; #1;
        check_eq("t4_rel_req", {31'h0, imem_req}, 32'h1);
        check_eq("t4_rel_addr", imem_addr, 32'h108);
        tick();
        check_eq("t4_buf_pc", id_pc, 32'h104);
        check_eq("t4_buf_inst", id_inst, inst_of(32'h104));
        check_eq("t4_buf_valid", {31'h0, id_valid}, 32'h1);

        // 5: PC wraps past the top of the address space
        br = 1'b1; tgt = 32'hFFFF_FFFF; lat = 1;
        tick();
        br = 1'b0; #1;
        for (int n = 0; n < 10 && !imem_req; n++) tick();
        check_eq("t5_req_top", {31'h0, imem_req}, 32'h1);
        check_eq("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("t5_wrap_req", {31'h0, imem_req}, 32'h1);
        check_eq("t5_wrap_addr", imem_addr, 32'h0);
        tick();
        check_eq("t5_id_pc_top", id_pc, 32'hFFFF_FFFC);
        check_eq("t5_id_valid", {31'h0, id_valid}, 32'h1);

        // 6: reset in S_WAIT, then in S_FULL
        rst = 1'b1; #1;
        check_eq("t6w_busy", {31'h0, busy}, 32'h0);
        check_eq("t6w_req", {31'h0, imem_req}, 32'h0);
        tick();
        check_eq("t6w_valid", {31'h0, id_valid}, 32'h0);
        check_eq("t6w_inst", id_inst, NOP);
        check_eq("t6w_pc", id_pc, 32'h0);
        check_eq("t6w_addr", imem_addr, 32'h0);
        rst = 1'b0; #1;
        check_eq("t6w_req0", {31'h0, imem_req}, 32'h1);
        tick();
        pc_en = 1'b0;
        tick();
        check_eq("t6f_full_addr", imem_addr, 32'h4);
        check_eq("t6f_full_req", {31'h0, imem_req}, 32'h0);
        rst = 1'b1; pc_en = 1'b1;
        tick();
        check_eq("t6f_valid", {31'h0, id_valid}, 32'h0);
        check_eq("t6f_addr", imem_addr, 32'h0);
        rst = 1'b0; #1;
        check_eq("t6f_req0", {31'h0, imem_req}, 32'h1);
        check_eq("t6f_addr0", imem_addr, 32'h0);
        tick(); tick();
        check_eq("t6f_id_pc0", id_pc, 32'h0);
        check_eq("t6f_id_valid", {31'h0, id_valid}, 32'h1);
        check_eq("t6f_id_inst0", id_inst, inst_of(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
